div_sched: RTL and testbench

Shares one iterative signed divider between the two per-pixel divisions of the perspective mapping: x = num_x/denom and y = num_y/denom.
- Accepts operand pairs on two independent valid/ready channels (X, Y) and arbitrates round-robin.
- Drives the divider's start/operand inputs and waits for its ready.
- Returns each quotient on a registered per-channel done pulse.
- Handles divide-by-zero locally without using the divider.
- Aborts hung operations with a watchdog.
- Sits between the num/denom accumulators and the shared `divider` instance in the pixel-mapping path.

---
 rtl/div_sched.sv | 95 +++++++++
 tb/tb_div_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one iterative signed divider between X and Y channels
module div_sched #(
  parameter int WIDTH   = 79,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_valid,
  input  logic [WIDTH-1:0] x_dividend,
  input  logic [WIDTH-1:0] x_divisor,
  output logic             x_ready,
  input  logic             y_valid,
  input  logic [WIDTH-1:0] y_dividend,
  input  logic [WIDTH-1:0] y_divisor,
  output logic             y_ready,
  output logic             x_done,
  output logic [WIDTH-1:0] x_quot,
  output logic             x_err,
  output logic             y_done,
  output logic [WIDTH-1:0] y_quot,
  output logic             y_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  output logic             div_sign,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_ready
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic prio, owner, grant_x, xfer, sel, div0, capture, abort, fin_x, fin_y, fin_err;
  logic [WIDTH-1:0] a, b, sat, fin_q;
  assign div_sign = 1'b1;
  always_comb begin
    grant_x  = x_valid & (~y_valid | ~prio);
    x_ready  = ~reset & (state == IDLE) & grant_x;
    y_ready  = ~reset & (state == IDLE) & y_valid & ~grant_x;
    xfer     = x_ready | y_ready;
    sel      = y_ready;
    a        = sel ? y_dividend : x_dividend;
    b        = sel ? y_divisor : x_divisor;
    div0     = b == '0;
    sat      = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : (a == '0 ? '0 : {1'b0, {(WIDTH-1){1'b1}}});
    // the first WAIT cycle (cnt==0) never captures, so a ready left over from the last op is skipped
    capture  = (state == WAIT) & (cnt != '0) & div_ready;
    abort    = (state == WAIT) & ~capture & (cnt == TMAX);
    fin_x    = (xfer & div0 & ~sel) | ((capture | abort) & ~owner);
    fin_y    = (xfer & div0 & sel) | ((capture | abort) & owner);
    fin_q    = xfer ? sat : (capture ? div_quotient : '0);
    fin_err  = xfer | abort;
    state_nx = (state == START) ? WAIT :
               (xfer & ~div0) ? START :
               (capture | abort) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      prio         <= 1'b0;
      owner        <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      x_done       <= 1'b0;
      x_quot       <= '0;
      x_err        <= 1'b0;
      y_done       <= 1'b0;
      y_quot       <= '0;
      y_err        <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= (state == WAIT) ? cnt + 1'b1 : '0;
      div_start <= xfer & ~div0;
      x_done    <= fin_x;
      y_done    <= fin_y;
      if (xfer & x_valid & y_valid) prio <= ~sel;
      if (xfer & ~div0) begin
        owner        <= sel;
        div_dividend <= a;
        div_divisor  <= b;
      end
      if (fin_x) begin
        x_quot <= fin_q;
        x_err  <= fin_err;
      end
      if (fin_y) begin
        y_quot <= fin_q;
        y_err  <= fin_err;
      end
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: table-driven and sequence checks of div_sched against a behavioural divider
module tb_div_sched;
  localparam int W  = 79;
  localparam int TO = 48;
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
  logic clk = 1'b0, reset = 1'b1;
  logic x_valid = 1'b0, y_valid = 1'b0;
  logic [W-1:0] x_dividend = '0, x_divisor = '0, y_dividend = '0, y_divisor = '0;
  logic x_ready, y_ready, x_done, x_err, y_done, y_err, div_start, div_sign, div_ready;
  logic [W-1:0] x_quot, y_quot, div_dividend, div_divisor, div_quotient;
  always #5 clk = ~clk;
  div_sched #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .x_valid(x_valid), .x_dividend(x_dividend), .x_divisor(x_divisor), .x_ready(x_ready),
    .y_valid(y_valid), .y_dividend(y_dividend), .y_divisor(y_divisor), .y_ready(y_ready),
    .x_done(x_done), .x_quot(x_quot), .x_err(x_err),
    .y_done(y_done), .y_quot(y_quot), .y_err(y_err),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_sign(div_sign), .div_quotient(div_quotient), .div_ready(div_ready)
  );
  int lat = 1;
  bit sticky = 1'b0, hang = 1'b0;
  int mcnt = 0;
  logic m_ready = 1'b0;
  logic signed [W-1:0] m_quot = '0;
  assign div_ready = m_ready;
  assign div_quotient = m_quot;
  always @(posedge clk) begin
    if (div_start) begin
      mcnt <= lat;
      if (!sticky) m_ready <= 1'b0;
    end else if (mcnt == 1) begin
      mcnt <= 0;
      if (!hang) begin
        m_ready <= 1'b1;
        m_quot  <= $signed(div_dividend) / $signed(div_divisor);
      end
    end else begin
      if (mcnt > 0) mcnt <= mcnt - 1;
      if (!sticky) m_ready <= 1'b0;
    end
  end
  int cyc = 0, xd_cnt = 0, yd_cnt = 0, ds_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (x_done) xd_cnt <= xd_cnt + 1;
    if (y_done) yd_cnt <= yd_cnt + 1;
    if (div_start) ds_cnt <= ds_cnt + 1;
  end
  int total = 0, passed = 0;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic wait_done(input bit ch, output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      if (ch ? y_done : x_done) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask
  typedef struct {
    logic signed [W-1:0] a, b;
    int lat;
    logic signed [W-1:0] q;
    logic err;
  } vec_t;
  vec_t v[9];
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, t2, c, ds0, xd0;
    v[0] = '{100, 7, 40, 14, 1'b0};
    v[1] = '{-90, 9, 3, -10, 1'b0};
    v[2] = '{7, -2, 1, -3, 1'b0};
    v[3] = '{-7, 2, 5, -3, 1'b0};
    v[4] = '{5, 0, 0, MAXP, 1'b1};
    v[5] = '{-3, 0, 0, MINN, 1'b1};
    v[6] = '{0, 0, 0, 0, 1'b1};
    v[7] = '{0, 5, 2, 0, 1'b0};
    v[8] = '{MAXP, 1, 4, MAXP, 1'b0};
    // reset state, with a request already pending
    x_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_x_ready", x_ready, 0);
    chk("rst_x_done", x_done, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_x_quot", x_quot, 0);
    chk("rst_div_sign", div_sign, 1);
    x_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    // single X requests from the table
    for (int i = 0; i < 9; i++) begin
      lat = v[i].lat;
      x_dividend = v[i].a;
      x_divisor = v[i].b;
      x_valid = 1'b1;
      ds0 = ds_cnt;
      #1;
      chk("x_ready", x_ready, 1);
      t = cyc;
      @(negedge clk);
      x_valid = 1'b0;
      if (v[i].b != 0) begin
        chk("div_start", div_start, 1);
        chk("div_dividend", div_dividend, v[i].a);
        chk("div_divisor", div_divisor, v[i].b);
      end
      wait_done(1'b0, c);
      chk("x_done_cycle", c, v[i].b == 0 ? t + 1 : t + v[i].lat + 3);
      chk("x_quot", x_quot, v[i].q);
      chk("x_err", x_err, v[i].err);
      if (v[i].b == 0) chk("div0_no_start", ds_cnt, ds0);
      @(negedge clk);
    end
    chk("y_done_never", yd_cnt, 0);
    // Y divide-by-zero, back to back
    ds0 = ds_cnt;
    y_dividend = -3;
    y_divisor = 0;
    y_valid = 1'b1;
    #1;
    chk("y0_ready", y_ready, 1);
    @(negedge clk);
    chk("y0_done", y_done, 1);
    chk("y0_quot", y_quot, MINN);
    chk("y0_err", y_err, 1);
    y_dividend = 0;
    #1;
    chk("y0b_ready", y_ready, 1);
    @(negedge clk);
    y_valid = 1'b0;
    chk("y0b_done", y_done, 1);
    chk("y0b_quot", y_quot, 0);
    chk("y0b_err", y_err, 1);
    chk("y0_no_start", ds_cnt, ds0);
    @(negedge clk);
    // stale ready held high by the divider must not be taken in the first WAIT cycle
    sticky = 1'b1;
    lat = 1;
    x_dividend = 30;
    x_divisor = 3;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    wait_done(1'b0, c);
    chk("st1_quot", x_quot, 10);
    @(negedge clk);
    x_dividend = 12;
    x_divisor = -4;
    x_valid = 1'b1;
    #1;
    t = cyc;
    @(negedge clk);
    x_valid = 1'b0;
    wait_done(1'b0, c);
    chk("st2_cycle", c, t + 4);
    chk("st2_quot", x_quot, -3);
    sticky = 1'b0;
    repeat (3) @(negedge clk);
    // simultaneous X and Y after reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lat = 3;
    x_dividend = -90; x_divisor = 9;
    y_dividend = 50;  y_divisor = 5;
    x_valid = 1'b1; y_valid = 1'b1;
    #1;
    chk("xy_x_ready", x_ready, 1);
    chk("xy_y_ready", y_ready, 0);
    t = cyc;
    @(negedge clk);
    x_valid = 1'b0;
    #1;
    chk("xy_busy_y_ready", y_ready, 0);
    wait_done(1'b0, c);
    chk("xy_x_cycle", c, t + 6);
    chk("xy_x_quot", x_quot, -10);
    #1;
    chk("xy_y_on_done", y_ready, 1);
    t2 = cyc;
    @(negedge clk);
    y_valid = 1'b0;
    wait_done(1'b1, c);
    chk("xy_y_cycle", c, t2 + 6);
    chk("xy_y_quot", y_quot, 10);
    @(negedge clk);
    x_valid = 1'b1; y_valid = 1'b1;
    #1;
    chk("rr_y_ready", y_ready, 1);
    chk("rr_x_ready", x_ready, 0);
    @(negedge clk);
    y_valid = 1'b0;
    wait_done(1'b1, c);
    #1;
    chk("rr_x_after", x_ready, 1);
    @(negedge clk);
    x_valid = 1'b0;
    wait_done(1'b0, c);
    chk("rr_x_quot", x_quot, -10);
    @(negedge clk);
    // watchdog abort, then Y is served
    hang = 1'b1;
    x_dividend = 9; x_divisor = 3;
    x_valid = 1'b1;
    #1;
    t = cyc;
    @(negedge clk);
    x_valid = 1'b0;
    y_dividend = 20; y_divisor = 4;
    y_valid = 1'b1;
    #1;
    chk("to_y_blocked", y_ready, 0);
    wait_done(1'b0, c);
    hang = 1'b0;
    chk("to_cycle", c, t + TO + 3);
    chk("to_err", x_err, 1);
    chk("to_quot", x_quot, 0);
    #1;
    chk("to_y_ready", y_ready, 1);
    t2 = cyc;
    @(negedge clk);
    y_valid = 1'b0;
    wait_done(1'b1, c);
    chk("to_y_cycle", c, t2 + 6);
    chk("to_y_quot", y_quot, 5);
    chk("to_y_err", y_err, 0);
    @(negedge clk);
    // reset during WAIT
    lat = 10;
    x_dividend = 100; x_divisor = 7;
    y_dividend = 8;   y_divisor = 2;
    x_valid = 1'b1; y_valid = 1'b1;
    #1;
    chk("mr_x_ready", x_ready, 1);
    @(negedge clk);
    x_valid = 1'b0; y_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_x_done", x_done, 0);
    chk("mr_x_err", x_err, 0);
    chk("mr_x_quot", x_quot, 0);
    chk("mr_y_quot", y_quot, 0);
    chk("mr_div_start", div_start, 0);
    chk("mr_div_dividend", div_dividend, 0);
    chk("mr_div_divisor", div_divisor, 0);
    xd0 = xd_cnt;
    repeat (15) @(negedge clk);
    chk("mr_no_late_done", xd_cnt, xd0);
    lat = 2;
    x_dividend = 21; x_divisor = 7;
    x_valid = 1'b1; y_valid = 1'b1;
    #1;
    chk("mr_prio_x", x_ready, 1);
    chk("mr_prio_y", y_ready, 0);
    t = cyc;
    @(negedge clk);
    x_valid = 1'b0;
    wait_done(1'b0, c);
    chk("mr_x_cycle", c, t + 5);
    chk("mr_x_quot2", x_quot, 3);
    #1;
    chk("mr_y_ready", y_ready, 1);
    @(negedge clk);
    y_valid = 1'b0;
    wait_done(1'b1, c);
    chk("mr_y_quot2", y_quot, 4);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
